// File: rtl/wb_pkg.sv
// Shared constants and helpers for the writeback arbiter and its scoreboard.
package wb_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned N_SRC_MAX = 4;
  localparam int unsigned NREGS     = 32;
  localparam int unsigned IDX_W     = $clog2(N_SRC_MAX);

  // OR-reduction of bit positions; exact for one-hot input, zero for no bits set.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_SRC_MAX-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(N_SRC_MAX); i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: requester handshakes, register-file write port and scoreboard view.
interface wb_arbiter_if #(
  parameter int unsigned N_SRC = 3,
  parameter int unsigned XLEN  = wb_pkg::XLEN,
  parameter int unsigned REG_W = wb_pkg::REG_W
);
  import wb_pkg::*;

  logic [N_SRC-1:0]       req_v;
  logic [REG_W*N_SRC-1:0] req_rd;
  logic [XLEN*N_SRC-1:0]  req_d;
  logic [N_SRC-1:0]       req_rdy;
  logic [XLEN-1:0]        rf_d;
  logic [REG_W-1:0]       rf_rd;
  logic                   rf_wr;
  logic                   iss_v;
  logic [REG_W-1:0]       iss_rd;
  logic [REG_W-1:0]       chk_rs1;
  logic [REG_W-1:0]       chk_rs2;
  logic                   hazard;
  logic                   flush;
  logic [NREGS-1:0]       busy;

  modport slave (
    input  req_v, req_rd, req_d, iss_v, iss_rd, chk_rs1, chk_rs2, flush,
    output req_rdy, rf_d, rf_rd, rf_wr, hazard, busy
  );

  modport master (
    output req_v, req_rd, req_d, iss_v, iss_rd, chk_rs1, chk_rs2, flush,
    input  req_rdy, rf_d, rf_rd, rf_wr, hazard, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer, wrapping upward.
module rr_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW:0]   sum;
  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    sum   = '0;
    idx   = '0;
    found = 1'b0;
    // No grants while reset is held, so requesters cannot complete a handshake.
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        sum = {1'b0, ptr_q} + (PtrW+1)'(i);
        if (sum >= (PtrW+1)'(N)) sum = sum - (PtrW+1)'(N);
        idx = sum[PtrW-1:0];
        if (!found && req_i[idx]) begin
          found      = 1'b1;
          gnt_o[idx] = 1'b1;
          ptr_d      = (idx == PtrW'(N - 1)) ? '0 : idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the register-file write port among N_SRC producers and keeps
// the pending-destination scoreboard used for RAW stalls.
module wb_arbiter #(
  parameter int unsigned N_SRC = 3,
  parameter int unsigned XLEN  = wb_pkg::XLEN,
  parameter int unsigned REG_W = wb_pkg::REG_W
) (
  input logic        clk,
  input logic        rst,
  wb_arbiter_if.slave bus
);
  import wb_pkg::*;

  localparam int unsigned IdxW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] gnt;
  logic [IdxW-1:0]  gnt_idx;
  logic [XLEN-1:0]  src_d  [N_SRC];
  logic [REG_W-1:0] src_rd [N_SRC];

  logic [XLEN-1:0]  rf_d_q, rf_d_d;
  logic [REG_W-1:0] rf_rd_q, rf_rd_d;
  logic             rf_wr_q, rf_wr_d;
  logic [NREGS-1:0] busy_q, busy_d;

  rr_arbiter #(
    .N (N_SRC)
  ) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req_i (bus.req_v),
    .gnt_o (gnt)
  );

  for (genvar n = 0; n < int'(N_SRC); n++) begin : g_src
    assign src_d[n]  = bus.req_d[XLEN*n +: XLEN];
    assign src_rd[n] = bus.req_rd[REG_W*n +: REG_W];
  end

  assign gnt_idx = IdxW'(onehot_to_idx(N_SRC_MAX'(gnt)));

  always_comb begin
    rf_d_d  = rf_d_q;
    rf_rd_d = rf_rd_q;
    rf_wr_d = 1'b0;
    if (|gnt) begin
      rf_d_d  = src_d[gnt_idx];
      rf_rd_d = src_rd[gnt_idx];
      // Writes to x0 complete the handshake but never reach the register file.
      rf_wr_d = (src_rd[gnt_idx] != '0);
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (rf_wr_q && rf_rd_q != '0) busy_d[rf_rd_q] = 1'b0;
    // Set after clear: a newly issued producer owns the register over the retiring one.
    if (bus.iss_v && bus.iss_rd != '0) busy_d[bus.iss_rd] = 1'b1;
    if (bus.flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_d_q  <= '0;
      rf_rd_q <= '0;
      rf_wr_q <= 1'b0;
      busy_q  <= '0;
    end else begin
      rf_d_q  <= rf_d_d;
      rf_rd_q <= rf_rd_d;
      rf_wr_q <= rf_wr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.req_rdy = gnt;
  assign bus.rf_d    = rf_d_q;
  assign bus.rf_rd   = rf_rd_q;
  assign bus.rf_wr   = rf_wr_q;
  assign bus.busy    = busy_q;
  assign bus.hazard  = busy_q[bus.chk_rs1] | busy_q[bus.chk_rs2];

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register file write port (d/rd/wr) between N_SRC writeback producers (ALU, load unit, mul/div) using round-robin valid/ready arbitration.
- Drives the write port from registered outputs.
- Keeps a 32-bit pending-destination scoreboard that the issue stage uses to stall on RAW hazards.
- Sits between the execute/memory units and the register file; the hazard output feeds issue-stage stall logic.

Parameters:
N_SRC, 3, number of writeback requesters (2..4)
XLEN, 64, data width
REG_W, 5, register index width

Ports:
clk  in  1  clock, posedge
rst  in  1  asynchronous, active-high reset
req_v  in  N_SRC  requester n has a write pending
req_rd  in  REG_W*N_SRC  destination of requester n, slice [REG_W*n +: REG_W]
req_d  in  XLEN*N_SRC  data of requester n, slice [XLEN*n +: XLEN]
req_rdy  out  N_SRC  one-hot grant; transfer when req_v[n] && req_rdy[n]
rf_d  out  XLEN  register file write data
rf_rd  out  REG_W  register file write index
rf_wr  out  1  register file write enable
iss_v  in  1  issue stage dispatches an instruction writing iss_rd
iss_rd  in  REG_W  destination of the issued instruction
chk_rs1  in  REG_W  source 1 under hazard check
chk_rs2  in  REG_W  source 2 under hazard check
hazard  out  1  busy[chk_rs1] | busy[chk_rs2], combinational
flush  in  1  pipeline flush; clears the scoreboard
busy  out  32  pending-destination bitmap, registered; bit 0 is always 0

Behaviour:
- Reset (async, rst=1): rf_wr=0, rf_rd=0, rf_d=0, busy=0, round-robin pointer=0, req_rdy=0 while rst is held.
- Arbitration (combinational):
  - Among the asserted req_v bits, grant the first at or after the pointer, searching upward with wrap.
  - req_rdy is one-hot or zero.
  - req_rdy[n] never asserts without req_v[n].
- Pointer update: after a grant to n, the pointer becomes (n+1) mod N_SRC. With no grant, the pointer holds.
- Write port:
  - A grant in cycle T registers rf_d, rf_rd and rf_wr=1, which are visible in cycle T+1.
  - The register file writes at the end of T+1. Latency from accept to write is 1 cycle.
  - With no grant, rf_wr=0 next cycle and rf_d/rf_rd hold their values.
  - A granted request with rd=0 is accepted (handshake completes) but produces rf_wr=0.
- Throughput: one write per cycle. A persistent requester waits at most N_SRC-1 cycles for a grant.
- Requester contract: while req_v is high and not yet granted, req_rd and req_d stay stable. A bench assertion checks this.
- Scoreboard:
  - Set: iss_v && iss_rd!=0 sets busy[iss_rd] at the next edge.
  - Clear: rf_wr && rf_rd!=0 clears busy[rf_rd] at the same edge the register file writes. A read in the following cycle sees both the new value and busy=0.
  - Simultaneous set and clear of the same index: set wins, because the newer producer owns the register.
  - flush=1 clears all busy bits at the next edge and takes priority over iss_v in the same cycle.
  - flush does not affect arbitration or an in-flight rf_wr.
- hazard: pure combinational function of the current busy register and chk_rs1/chk_rs2. Index 0 never causes a hazard.
- WAW: the issue stage must not issue to a register already busy. A bench assertion flags iss_v with busy[iss_rd]=1 and flush=0.
- Reset asserted mid-operation: the pending rf_wr is dropped and the scoreboard is cleared. Requesters must re-present after reset.

Decomposition:
- Package wb_pkg holds:
  - XLEN, REG_W, N_SRC_MAX, NREGS=32
  - A helper function onehot_to_idx
- Sub-module rr_arbiter (parameter N):
  - Combinational request-to-grant logic plus the registered pointer.
  - Same clk/rst convention.
  - Reusable for other shared ports.
- wb_arbiter contains the output registers, the data/rd mux and the scoreboard.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> rf_wr=0, busy=0, req_rdy=0 immediately (async); after release with no requests, rf_wr stays 0.
- Single source:
  - Stimulus: req_v=001, rd=5, d=0xDEAD_BEEF in cycle T.
  - Response: req_rdy=001 in T; rf_wr=1, rf_rd=5, rf_d=0xDEADBEEF in T+1; rf_wr=0 in T+2.
- All sources held valid with rd=1,2,3 for 6 cycles -> grants 0,1,2,0,1,2; rf_rd sequence 1,2,3,1,2,3; no cycle has two grants.
- Scoreboard round trip:
  - Stimulus: iss_v with rd=7, then chk_rs1=7.
  - Response: busy[7]=1 and hazard=1 until source 1 writes rd=7; busy[7]=0 and hazard=0 the cycle after rf_wr.
- Set/clear collision: iss_v rd=9 in the same cycle rf_wr targets rd=9 -> busy[9]=1 afterwards.
- Zero-register and flush cases:
  - Request with rd=0 -> accepted, rf_wr=0.
  - iss_rd=0 -> busy unchanged.
  - flush with busy=0x0000_00F0 plus iss_v rd=3 -> busy=0 next cycle.
